nbcac_tx_scheduler: RTL and testbench

- Round-robin burst scheduler that shares one `nbcac_18di_encoder_core` (18-bit data in, 26-bit CAC codeword out) among `N_REQ` requesters.
- Each requester offers 18-bit words over valid/ready and keeps the encoder for a burst.
- The burst ends on `req_last` or after `BURST_MAX` words.
- Output is a single registered codeword slot with valid/ready toward the link driver. The slot holds the codeword unchanged while idle, so the bus does not toggle.

---
 rtl/nbcac_pkg.sv | 18 +
 rtl/nbcac_18di_encoder_core.sv | 25 ++
 rtl/nbcac_rr_picker.sv | 30 +++
 rtl/nbcac_tx_scheduler.sv | 139 +++++++++++++
 tb/tb_nbcac_tx_scheduler.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/nbcac_pkg.sv
// Shared types and constants for the NBCAC transmit path.
package nbcac_pkg;

  localparam int unsigned NBCAC_DW = 18;
  localparam int unsigned NBCAC_CW = 26;

  // Fibonacci weights for codeword bit positions 0..25 (LSB first).
  localparam int unsigned NBCAC_FIB [NBCAC_CW] = '{
    1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987,
    1597, 2584, 4181, 6765, 10946, 17711, 28657, 46368, 75025, 121393
  };

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } nbcac_sched_state_t;

endpackage

// File: rtl/nbcac_18di_encoder_core.sv
// 18-bit data to 26-bit Fibonacci-based CAC codeword; purely combinational.
module nbcac_18di_encoder_core
  import nbcac_pkg::*;
(
  input  logic [NBCAC_DW-1:0] d,
  output logic [NBCAC_CW:1]   v
);

  localparam int unsigned RW = NBCAC_DW + 1;

  logic [RW-1:0] rem;

  // Greedy MSB-first decomposition over the Fibonacci weights.
  always_comb begin
    v   = '0;
    rem = {1'b0, d};
    for (int unsigned k = NBCAC_CW; k >= 1; k--) begin
      if (rem >= RW'(NBCAC_FIB[k-1])) begin
        v[k] = 1'b1;
        rem  = rem - RW'(NBCAC_FIB[k-1]);
      end
    end
  end

endmodule

// File: rtl/nbcac_rr_picker.sv
// Cyclic find-first: first set bit of vld searching upward from ptr, wrapping at N.
module nbcac_rr_picker #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  vld,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam int unsigned CW = IW + 1;

  logic [CW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = {1'b0, ptr} + CW'(k);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      if (!found && vld[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/nbcac_tx_scheduler.sv
// Round-robin burst scheduler sharing one CAC encoder among N_REQ requesters,
// feeding a single registered codeword slot.
module nbcac_tx_scheduler
  import nbcac_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned BURST_MAX = 8
) (
  input  logic                          clock,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*NBCAC_DW-1:0]     req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  output logic [NBCAC_CW:1]             codeout,
  output logic                          code_valid,
  output logic [$clog2(N_REQ)-1:0]      code_src,
  output logic                          code_last,
  input  logic                          out_ready
);

  localparam int unsigned IW   = $clog2(N_REQ);
  localparam int unsigned CNTW = $clog2(BURST_MAX) + 1;

  nbcac_sched_state_t state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;

  logic               found;
  logic [IW-1:0]      winner;
  logic [IW-1:0]      sel;
  logic               sel_valid;
  logic               slot_free;
  logic               xfer;
  logic               eob;
  logic [CNTW-1:0]    cnt_eff;
  logic [NBCAC_DW-1:0] enc_d;
  logic [NBCAC_CW:1]  enc_v;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (p == IW'(N_REQ - 1)) ? '0 : p + IW'(1);
  endfunction

  nbcac_rr_picker #(
    .N  (N_REQ),
    .IW (IW)
  ) u_picker (
    .vld   (req_valid),
    .ptr   (rr_ptr_q),
    .found (found),
    .idx   (winner)
  );

  nbcac_18di_encoder_core u_enc (
    .d (enc_d),
    .v (enc_v)
  );

  // Grant path stays independent of req_data/req_last; only eob uses req_last.
  always_comb begin
    sel       = (state_q == BURST) ? owner_q : winner;
    sel_valid = (state_q == BURST) ? req_valid[owner_q] : found;
    cnt_eff   = (state_q == BURST) ? cnt_q : '0;
    slot_free = !code_valid || out_ready;
    xfer      = rst_n && sel_valid && slot_free;
    req_ready = '0;
    if (xfer) req_ready[sel] = 1'b1;
    eob = req_last[sel] || (cnt_eff == CNTW'(BURST_MAX - 1));
    enc_d = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (sel == IW'(i)) enc_d = req_data[i*NBCAC_DW +: NBCAC_DW];
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          if (eob) begin
            rr_ptr_d = ptr_inc(sel);
          end else begin
            state_d = BURST;
            owner_d = sel;
            cnt_d   = CNTW'(1);
          end
        end
      end
      BURST: begin
        if (xfer) begin
          if (eob) begin
            state_d  = IDLE;
            rr_ptr_d = ptr_inc(owner_q);
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  // Slot contents only change on a load so the link bus stays quiet when idle.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      codeout    <= '0;
      code_valid <= 1'b0;
      code_src   <= '0;
      code_last  <= 1'b0;
    end else if (xfer) begin
      codeout    <= enc_v;
      code_valid <= 1'b1;
      code_src   <= sel;
      code_last  <= eob;
    end else if (out_ready) begin
      code_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nbcac_tx_scheduler.sv
// Directed self-checking bench for nbcac_tx_scheduler (N_REQ=4, BURST_MAX=8).
module tb_nbcac_tx_scheduler;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [71:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [26:1] codeout;
  logic        code_valid;
  logic [1:0]  code_src;
  logic        code_last;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  nbcac_tx_scheduler #(
    .N_REQ     (4),
    .BURST_MAX (8)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .codeout    (codeout),
    .code_valid (code_valid),
    .code_src   (code_src),
    .code_last  (code_last),
    .out_ready  (out_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic set_data(input int unsigned i, input logic [17:0] d);
    req_data[i*18 +: 18] = d;
  endtask

  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    tick();
    rst_n = 1'b1;
  endtask

  // Reference Fibonacci encoder: greedy from the largest weight down.
  function automatic logic [25:0] enc_ref(input int unsigned d);
    int unsigned fib [26];
    int unsigned r;
    logic [25:0] res;
    fib[0] = 1;
    fib[1] = 1;
    for (int k = 2; k < 26; k++) fib[k] = fib[k-1] + fib[k-2];
    r   = d;
    res = '0;
    for (int k = 25; k >= 0; k--) begin
      if (r >= fib[k]) begin
        res[k] = 1'b1;
        r      = r - fib[k];
      end
    end
    return res;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned exp_src  [10];
    int unsigned exp_dat  [10];
    logic        exp_last [10];
    logic [3:0]  rdy;
    int unsigned d2;

    // Reset with all requesters valid
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    req_data  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_data(i, 18'(i + 1));
    tick(); tick(); tick();
    check_eq("rst_codeout", 32'(codeout), 32'd0);
    check_eq("rst_valid", 32'(code_valid), 32'd0);
    check_eq("rst_src", 32'(code_src), 32'd0);
    check_eq("rst_last", 32'(code_last), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_ready", 32'(req_ready), 32'b0001);

    // Round-robin of single-word bursts; data i+1 encodes to 2,4,8,10
    begin
      int unsigned rr_src [6] = '{0, 1, 2, 3, 0, 1};
      int unsigned rr_cod [6] = '{2, 4, 8, 10, 2, 4};
      for (int j = 0; j < 6; j++) begin
        tick();
        check_eq($sformatf("rr_src%0d", j), 32'(code_src), rr_src[j]);
        check_eq($sformatf("rr_code%0d", j), 32'(codeout), rr_cod[j]);
        check_eq($sformatf("rr_valid%0d", j), 32'(code_valid), 32'd1);
        check_eq($sformatf("rr_last%0d", j), 32'(code_last), 32'd1);
      end
    end
    req_valid = '0;
    tick();
    check_eq("idle_valid", 32'(code_valid), 32'd0);
    check_eq("idle_hold", 32'(codeout), 32'd4);

    // Burst cap: rr_ptr is now 2; req2 streams, req0 single word
    exp_src  = '{2, 2, 2, 2, 2, 2, 2, 2, 0, 2};
    exp_dat  = '{100, 101, 102, 103, 104, 105, 106, 107, 7, 108};
    exp_last = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0};
    req_valid = 4'b0101;
    req_last  = 4'b0001;
    d2 = 100;
    for (int j = 0; j < 10; j++) begin
      set_data(2, 18'(d2));
      set_data(0, 18'd7);
      #1;
      rdy = req_ready;
      check_eq($sformatf("cap_ready%0d", j), 32'(rdy), (exp_src[j] == 2) ? 32'b0100 : 32'b0001);
      tick();
      if (rdy[2]) d2++;
      check_eq($sformatf("cap_src%0d", j), 32'(code_src), exp_src[j]);
      check_eq($sformatf("cap_last%0d", j), 32'(code_last), 32'(exp_last[j]));
      check_eq($sformatf("cap_code%0d", j), 32'(codeout), 32'(enc_ref(exp_dat[j])));
    end
    do_reset();

    // Backpressure: slot holds while out_ready low, reload with no bubble
    req_valid = 4'b0001;
    req_last  = 4'b0001;
    set_data(0, 18'd5);
    out_ready = 1'b1;
    tick();
    check_eq("bp_first", 32'(codeout), 32'd16);
    set_data(0, 18'd6);
    out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      #1;
      check_eq($sformatf("bp_ready%0d", j), 32'(req_ready), 32'd0);
      tick();
      check_eq($sformatf("bp_hold%0d", j), 32'(codeout), 32'd16);
      check_eq($sformatf("bp_valid%0d", j), 32'(code_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", 32'(req_ready), 32'b0001);
    tick();
    check_eq("bp_next", 32'(codeout), 32'd18);
    check_eq("bp_next_valid", 32'(code_valid), 32'd1);
    do_reset();

    // Owner stall: req1 owns the grant and pauses while req3 waits
    req_valid = 4'b1010;
    req_last  = 4'b0000;
    set_data(1, 18'd20);
    set_data(3, 18'd30);
    tick();
    check_eq("stall_first_src", 32'(code_src), 32'd1);
    check_eq("stall_first_code", 32'(codeout), 32'(enc_ref(20)));
    req_valid = 4'b1000;
    for (int j = 0; j < 4; j++) begin
      #1;
      check_eq($sformatf("stall_ready%0d", j), 32'(req_ready), 32'd0);
      tick();
      check_eq($sformatf("stall_valid%0d", j), 32'(code_valid), 32'd0);
    end
    req_valid = 4'b1010;
    for (int w = 2; w <= 8; w++) begin
      set_data(1, 18'(19 + w));
      tick();
      check_eq($sformatf("resume_src%0d", w), 32'(code_src), 32'd1);
      check_eq($sformatf("resume_last%0d", w), 32'(code_last), (w == 8) ? 32'd1 : 32'd0);
      check_eq($sformatf("resume_code%0d", w), 32'(codeout), 32'(enc_ref(19 + w)));
    end
    req_valid = 4'b1000;
    tick();
    check_eq("after_stall_src", 32'(code_src), 32'd3);
    check_eq("after_stall_code", 32'(codeout), 32'(enc_ref(30)));
    do_reset();

    // Mid-burst reset from requester 2
    req_valid = 4'b0100;
    req_last  = 4'b0000;
    for (int j = 0; j < 3; j++) begin
      set_data(2, 18'(40 + j));
      tick();
    end
    check_eq("mid_src", 32'(code_src), 32'd2);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
    tick();
    check_eq("mid_rst_valid", 32'(code_valid), 32'd0);
    check_eq("mid_rst_code", 32'(codeout), 32'd0);
    check_eq("mid_rst_src", 32'(code_src), 32'd0);
    rst_n = 1'b1;
    req_valid = 4'b0101;
    set_data(0, 18'd3);
    #1;
    check_eq("mid_rel_ready", 32'(req_ready), 32'b0001);
    tick();
    check_eq("mid_rel_src", 32'(code_src), 32'd0);
    check_eq("mid_rel_code", 32'(codeout), 32'd8);
    check_eq("mid_rel_valid", 32'(code_valid), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
